// File: rtl/calc_pkg.sv
// calc_pkg: operation/state enums and width helpers shared by calc_core_n
// and its result converter.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_e;

    typedef enum logic [1:0] {
        SHOW_OPS,
        COMPUTE,
        CONVERT,
        SHOW_RES
    } state_e;

    // 10^k, used for the binary shadow updates on digit increments.
    function automatic longint unsigned pow10(input int unsigned k);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < k; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Binary width of one operand of the given digit count.
    function automatic int unsigned calc_ow(input int unsigned digits);
        return int'($clog2(pow10(digits)));
    endfunction

    // Binary width of a result spanning twice the operand digits.
    function automatic int unsigned calc_rw(input int unsigned digits);
        return int'($clog2(pow10(2 * digits)));
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle. The result
// register holds its value until a later conversion completes.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int unsigned RW = 14,
    parameter int unsigned ND = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [RW-1:0]     bin_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [4*ND-1:0]   bcd_o
);

    localparam int unsigned CW = $clog2(RW + 1);

    logic [RW-1:0]   bin_q;
    logic [4*ND-1:0] work_q;
    logic [4*ND-1:0] res_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    // The MS bit of the adjusted word is always shifted out, so it is not kept.
    logic [4*ND-2:0] work_adj;

    // Add-3 correction on every nibble of 5 or more before the shift.
    always_comb begin
        work_adj = work_q[4*ND-2:0];
        for (int unsigned i = 0; i < ND - 1; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        if (work_q[4*(ND-1) +: 4] >= 4'd5) begin
            work_adj[4*(ND-1) +: 3] = work_q[4*(ND-1) +: 3] + 3'd3;
        end
    end

    // Load on start, then shift one binary bit into the BCD word per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= '0;
            work_q <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                bin_q  <= bin_i;
                work_q <= '0;
                cnt_q  <= CW'(RW);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                work_q <= {work_adj, bin_q[RW-1]};
                bin_q  <= {bin_q[RW-2:0], 1'b0};
                cnt_q  <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_q  <= {work_adj, bin_q[RW-1]};
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = res_q;

endmodule

// File: rtl/calc_core_n.sv
// calc_core_n: two-operand BCD calculator core with per-digit operand entry,
// add/sub (single cycle), iterative mul/div and sequential BCD formatting.
// Build option CALC_SIGNED_EN: subtraction reports a negative magnitude via
// disp_neg; without it A<B clamps to 0 and disp_neg stays 0.
module calc_core_n
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [2*DIGITS-1:0]   B1,
    input  logic [3:0]            B2,
    input  logic                  push,
    output logic [8*DIGITS-1:0]   disp_bcd,
    output logic                  disp_neg,
    output logic                  disp_err,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned OW = calc_ow(DIGITS);
    localparam int unsigned RW = calc_rw(DIGITS);
    localparam int unsigned CW = $clog2(OW + 1);

    state_e                state_q;
    op_e                   op_q;
    op_e                   new_op;
    logic [2*DIGITS-1:0]   b1_prev_q;
    logic [3:0]            b2_prev_q;
    logic                  push_prev_q;
    logic [2*DIGITS-1:0]   b1_rise;
    logic [3:0]            b2_rise;
    logic                  push_rise;

    logic [4*DIGITS-1:0]   a_bcd_q, a_bcd_d, b_bcd_q, b_bcd_d;
    logic [OW-1:0]         a_bin_q, a_bin_d, b_bin_q, b_bin_d;

    logic [CW-1:0]         cnt_q;
    logic [RW-1:0]         acc_q, mcand_q;
    logic [OW-1:0]         opb_q, quo_q, rem_q;
    logic                  neg_q, divz_q, divz;

    logic [8*DIGITS-1:0]   disp_q;
    logic                  disp_neg_q, disp_err_q, busy_q, done_q;

    logic [RW-1:0]         a_ext, b_ext, sum, sub_mag, mul_acc_nx, res_val;
    logic                  sub_neg;
    logic [OW:0]           div_try;
    logic                  div_ge;
    logic [OW-1:0]         div_sub, rem_nx, quo_nx;

    logic                  conv_start, conv_busy, conv_done;
    logic [8*DIGITS-1:0]   conv_bcd;

    assign b1_rise   = B1 & ~b1_prev_q;
    assign b2_rise   = B2 & ~b2_prev_q;
    assign push_rise = push & ~push_prev_q;

    // Digit increments for every rising B1 bit; BCD and binary shadow move together.
    always_comb begin
        a_bcd_d = a_bcd_q;
        b_bcd_d = b_bcd_q;
        a_bin_d = a_bin_q;
        b_bin_d = b_bin_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (b1_rise[i]) begin
                if (a_bcd_q[4*(DIGITS-1-i) +: 4] == 4'd9) begin
                    a_bcd_d[4*(DIGITS-1-i) +: 4] = 4'd0;
                    a_bin_d = a_bin_d - OW'(9 * pow10(DIGITS - 1 - i));
                end else begin
                    a_bcd_d[4*(DIGITS-1-i) +: 4] = a_bcd_q[4*(DIGITS-1-i) +: 4] + 4'd1;
                    a_bin_d = a_bin_d + OW'(pow10(DIGITS - 1 - i));
                end
            end
            if (b1_rise[DIGITS+i]) begin
                if (b_bcd_q[4*(DIGITS-1-i) +: 4] == 4'd9) begin
                    b_bcd_d[4*(DIGITS-1-i) +: 4] = 4'd0;
                    b_bin_d = b_bin_d - OW'(9 * pow10(DIGITS - 1 - i));
                end else begin
                    b_bcd_d[4*(DIGITS-1-i) +: 4] = b_bcd_q[4*(DIGITS-1-i) +: 4] + 4'd1;
                    b_bin_d = b_bin_d + OW'(pow10(DIGITS - 1 - i));
                end
            end
        end
    end

    // Operation select with add > sub > mul > div priority.
    always_comb begin
        if (b2_rise[0])      new_op = OP_ADD;
        else if (b2_rise[1]) new_op = OP_SUB;
        else if (b2_rise[2]) new_op = OP_MUL;
        else                 new_op = OP_DIV;
    end

    assign divz = (new_op == OP_DIV) && (b_bin_q == '0);

    // Arithmetic datapath: single-cycle add/sub plus one mul/div iteration step.
    always_comb begin
        a_ext      = RW'(a_bin_q);
        b_ext      = RW'(b_bin_q);
        sum        = a_ext + b_ext;
`ifdef CALC_SIGNED_EN
        sub_neg    = (a_ext < b_ext);
        sub_mag    = sub_neg ? (b_ext - a_ext) : (a_ext - b_ext);
`else
        sub_neg    = 1'b0;
        sub_mag    = (a_ext < b_ext) ? '0 : (a_ext - b_ext);
`endif
        mul_acc_nx = acc_q + (opb_q[0] ? mcand_q : '0);
        div_try    = {rem_q, quo_q[OW-1]};
        div_ge     = (div_try >= {1'b0, opb_q});
        div_sub    = div_try[OW-1:0] - opb_q;
        rem_nx     = div_ge ? div_sub : div_try[OW-1:0];
        quo_nx     = {quo_q[OW-2:0], div_ge};
        case (op_q)
            OP_ADD:  res_val = sum;
            OP_SUB:  res_val = sub_mag;
            OP_MUL:  res_val = mul_acc_nx;
            default: res_val = RW'(quo_nx);
        endcase
    end

    // The converter is started on the final COMPUTE cycle with the combinational result.
    assign conv_start = (state_q == COMPUTE) && (cnt_q == CW'(1)) && !conv_busy;

    bin2bcd_seq #(
        .RW (RW),
        .ND (2 * DIGITS)
    ) u_conv (
        .clk_i   (clk_in),
        .rst_i   (rst),
        .start_i (conv_start),
        .bin_i   (res_val),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Control FSM with edge tracking, operand registers and registered display outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= SHOW_OPS;
            op_q        <= OP_ADD;
            b1_prev_q   <= '0;
            b2_prev_q   <= '0;
            push_prev_q <= 1'b0;
            a_bcd_q     <= '0;
            b_bcd_q     <= '0;
            a_bin_q     <= '0;
            b_bin_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            opb_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            neg_q       <= 1'b0;
            divz_q      <= 1'b0;
            disp_q      <= '0;
            disp_neg_q  <= 1'b0;
            disp_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            b1_prev_q   <= B1;
            b2_prev_q   <= B2;
            push_prev_q <= push;
            done_q      <= 1'b0;
            case (state_q)
                SHOW_OPS, SHOW_RES: begin
                    // busy_q still high here only in the done cycle; edges are ignored then.
                    busy_q <= 1'b0;
                    if (!busy_q) begin
                        if (|b1_rise) begin
                            a_bcd_q    <= a_bcd_d;
                            b_bcd_q    <= b_bcd_d;
                            a_bin_q    <= a_bin_d;
                            b_bin_q    <= b_bin_d;
                            disp_q     <= {a_bcd_d, b_bcd_d};
                            disp_neg_q <= 1'b0;
                            disp_err_q <= 1'b0;
                            state_q    <= SHOW_OPS;
                        end else if (|b2_rise) begin
                            op_q    <= new_op;
                            cnt_q   <= (new_op == OP_MUL || new_op == OP_DIV) ? CW'(OW) : CW'(1);
                            acc_q   <= '0;
                            mcand_q <= a_ext;
                            opb_q   <= b_bin_q;
                            quo_q   <= a_bin_q;
                            rem_q   <= '0;
                            neg_q   <= 1'b0;
                            divz_q  <= divz;
                            busy_q  <= 1'b1;
                            state_q <= divz ? CONVERT : COMPUTE;
                        end else if (push_rise && state_q == SHOW_RES) begin
                            disp_q     <= {a_bcd_q, b_bcd_q};
                            disp_neg_q <= 1'b0;
                            disp_err_q <= 1'b0;
                            state_q    <= SHOW_OPS;
                        end
                    end
                end
                COMPUTE: begin
                    busy_q  <= 1'b1;
                    cnt_q   <= cnt_q - CW'(1);
                    acc_q   <= mul_acc_nx;
                    mcand_q <= {mcand_q[RW-2:0], 1'b0};
                    if (op_q == OP_MUL) begin
                        opb_q <= {1'b0, opb_q[OW-1:1]};
                    end
                    quo_q   <= quo_nx;
                    rem_q   <= rem_nx;
                    if (cnt_q == CW'(1)) begin
                        neg_q   <= (op_q == OP_SUB) && sub_neg;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    busy_q <= 1'b1;
                    // Divide by zero passes through here for one cycle without converting.
                    if (divz_q || conv_done) begin
                        disp_q     <= divz_q ? '0 : conv_bcd;
                        disp_neg_q <= neg_q & ~divz_q;
                        disp_err_q <= divz_q;
                        done_q     <= 1'b1;
                        state_q    <= SHOW_RES;
                    end
                end
                default: begin
                    state_q <= SHOW_OPS;
                end
            endcase
        end
    end

    assign disp_bcd = disp_q;
    assign disp_neg = disp_neg_q;
    assign disp_err = disp_err_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/calc_core_n.md
# calc_core_n

Parametrised calculator core: the next generation of the two-operand, 4-digit BCD calculator datapath. It owns operand entry (per-digit increment buttons), the four arithmetic operations, and binary-to-BCD result formatting. It presents a packed BCD digit word plus sign and error flags to the downstream 7-segment scan driver. Operand width scales with `DIGITS`. Multiply and divide are iterative, and negative subtraction results are optional.

## Interface
- `DIGITS`, default 2: BCD digits per operand. The display shows 2*DIGITS digits.
- `clk_in`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-high.
- `B1`  in  2*DIGITS: digit increment buttons.
  - Bit 0 is the MS digit of A; bit DIGITS-1 is the LS digit of A.
  - Bit DIGITS is the MS digit of B; bit 2*DIGITS-1 is the LS digit of B.
- `B2`  in  4: operation buttons: [0] add, [1] sub, [2] mul, [3] div.
- `push`  in  1: return display to operands.
- `disp_bcd`  out  8*DIGITS: 2*DIGITS BCD nibbles, MS digit in the top nibble.
- `disp_neg`  out  1: result is negative.
- `disp_err`  out  1: divide by zero.
- `busy`  out  1: computation in progress.
- `done`  out  1: one-cycle pulse when the result is valid.

## Operation
- All button inputs are already debounced and synchronised. The block acts only on rising edges: a registered previous value, with action when current=1 and previous=0.
- Operand entry:
  - A digit edge increments that digit mod 10, so 9 wraps to 0.
  - Each operand keeps a BCD register and a binary shadow of width OW=clog2(10^DIGITS).
  - The shadow is updated in the same cycle: +10^k normally, -9*10^k on wrap.
  - Simultaneous digit edges are all applied.
- FSM states: SHOW_OPS, COMPUTE, CONVERT, SHOW_RES.
  - SHOW_OPS: disp_bcd={A_bcd,B_bcd}, disp_neg=0, disp_err=0.
  - Op edge → COMPUTE. Priority when several op bits rise together: add > sub > mul > div.
  - COMPUTE:
    - add/sub: 1 cycle.
    - mul: shift-add over OW cycles.
    - div: restoring quotient over OW cycles; quotient truncated; remainder discarded.
  - CONVERT: sequential double-dabble on the RW-bit result, where RW=clog2(10^(2*DIGITS)). Takes RW cycles, then → SHOW_RES with a `done` pulse.
  - SHOW_RES: disp_bcd shows the result, zero-extended to 2*DIGITS digits.
    - `push` edge → SHOW_OPS.
    - Digit edge → apply the increment and go to SHOW_OPS.
    - Op edge → recompute from the current operands.
- While busy (COMPUTE/CONVERT): all B1, B2 and push edges are ignored (edge registers still track). disp_bcd, disp_neg and disp_err hold their previous values.
- Divide with B=0: skip COMPUTE. Result is 0, disp_err=1, done pulses after 1 cycle. disp_err clears on leaving SHOW_RES.
- Reset mid-operation: the FSM aborts to SHOW_OPS.

## Timing
- Reset values:
  - Operands 0.
  - disp_bcd=0, disp_neg=0, disp_err=0, busy=0, done=0.
  - FSM in SHOW_OPS.
  - Edge registers 0.
- Latency from the first cycle B2 is sampled high to `done`:
  - add/sub: 1+1+RW cycles (16 for DIGITS=2).
  - mul/div: 1+OW+RW cycles (22 for DIGITS=2).
- `busy` is high from the cycle after the edge through the `done` cycle inclusive. disp_bcd updates in the `done` cycle.
- A digit edge updates disp_bcd on the next clock.

## Configuration
- `CALC_SIGNED_EN` defined:
  - sub computes A-B in RW+1 bits.
  - If negative, the magnitude is converted and disp_neg=1 in SHOW_RES.
- `CALC_SIGNED_EN` undefined:
  - A<B clamps the result to 0.
  - disp_neg is tied to 0.

## Structure
- Package `calc_pkg`:
  - op enum (ADD, SUB, MUL, DIV) and FSM state enum.
  - Width functions for OW and RW.
  - Function giving 10^k for the shadow-register updates.
- Sub-module `bin2bcd_seq`:
  - Parametrised by RW.
  - start/busy/done handshake; holds its output until the next start.
  - Instantiated once for CONVERT.

## Test plan
DIGITS=2 throughout.
- Reset, then 9 edges on each B1 bit → disp_bcd=9999. Mul edge → done at +22 cycles, disp_bcd=9801.
- From 99 99:
  - add → 0198.
  - sub → 0000, disp_neg=0.
  - div → 0001.
  - push → 9999.
- 9 edges on B1[3] → 9998.
  - sub → 0001.
  - div → 0001.
- A=32, B=98 (4 edges on B1[0], 3 edges on B1[1] from 99 98):
  - sub → 0066 with disp_neg=1 (signed build), or 0000 with disp_neg=0 (unsigned build).
  - div → 0000.
  - mul → 3136.
- A=32, B=10 (2 edges each on B1[2] and B1[3]):
  - div → 0003.
  - Then wrap B to 00 with further B1[2]/B1[3] edges; div → disp_err=1, disp_bcd=0000, done 1 cycle after busy.
- Op edge and push edge during mul: both ignored, result still 9801.
  - rst asserted mid-mul → next cycle disp_bcd=0000, busy=0, done never pulses.
